// File: rtl/wb_stage_if.sv
// Write-back stage bus: upstream instruction/memory inputs and register-file write outputs.
interface wb_stage_if;
  localparam int unsigned DEST_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              freeze;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic [DEST_W-1:0] dest_in;
  logic [DATA_W-1:0] alu_res_in;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_ready;
  logic [DEST_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB;
  logic              writeBackEn;
  logic              wb_stall;
  logic [CNT_W-1:0]  wb_count;

  modport master (
    output freeze, wb_en_in, mem_r_en_in, dest_in, alu_res_in, mem_data_in, mem_ready,
    input  Dest_wb, Result_WB, writeBackEn, wb_stall, wb_count
  );

  modport slave (
    input  freeze, wb_en_in, mem_r_en_in, dest_in, alu_res_in, mem_data_in, mem_ready,
    output Dest_wb, Result_WB, writeBackEn, wb_stall, wb_count
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back pipeline stage: captures ALU results or load data and drives the
// register-file write port, stalling upstream while a load miss is outstanding.
module wb_stage (
  input logic     clk,
  input logic     rst,
  wb_stage_if.slave bus
);
  localparam int unsigned DEST_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {RUN, WAIT_LOAD} state_t;

  state_t            state;
  logic              valid;
  logic              wb_en_r;
  logic              mem_r_r;
  logic [DEST_W-1:0] dest_r;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] data_r;
  logic              pending;
  logic [CNT_W-1:0]  wb_count_r;
  logic              write_en_c;

  assign write_en_c = valid & wb_en_r & ~pending;

  // Stage registers and load-wait FSM; reset discards any outstanding load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      valid      <= 1'b0;
      pending    <= 1'b0;
      wb_en_r    <= 1'b0;
      mem_r_r    <= 1'b0;
      dest_r     <= '0;
      alu_r      <= '0;
      data_r     <= '0;
      wb_count_r <= '0;
    end else begin
      if (write_en_c) begin
        wb_count_r <= wb_count_r + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (!bus.freeze) begin
            valid   <= 1'b1;
            wb_en_r <= bus.wb_en_in;
            mem_r_r <= bus.mem_r_en_in;
            dest_r  <= bus.dest_in;
            alu_r   <= bus.alu_res_in;
            pending <= 1'b0;
            // Only a writing load waits on memory; a non-writing load is a no-op.
            if (bus.mem_r_en_in && bus.wb_en_in) begin
              if (bus.mem_ready) begin
                data_r <= bus.mem_data_in;
              end else begin
                pending <= 1'b1;
                state   <= WAIT_LOAD;
              end
            end
          end else begin
            valid   <= 1'b0;
            pending <= 1'b0;
          end
        end
        WAIT_LOAD: begin
          if (bus.mem_ready) begin
            data_r  <= bus.mem_data_in;
            pending <= 1'b0;
            state   <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.writeBackEn = write_en_c;
  assign bus.wb_stall    = (state == WAIT_LOAD);
  assign bus.Dest_wb     = dest_r;
  assign bus.Result_WB   = mem_r_r ? data_r : alu_r;
  assign bus.wb_count    = wb_count_r;
endmodule
